// File: rtl/rv_mem_pkg.sv
// Shared encodings for the MEM-stage data access path: funct3 codes, exception causes,
// access sequencer states and the alignment rule.
package rv_mem_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [3:0] CAUSE_LOAD_MISALIGNED  = 4'd4;
    localparam logic [3:0] CAUSE_LOAD_FAULT       = 4'd5;
    localparam logic [3:0] CAUSE_STORE_MISALIGNED = 4'd6;
    localparam logic [3:0] CAUSE_STORE_FAULT      = 4'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_DONE = 2'd3
    } mem_state_e;

    // funct3[1:0] is the access size for both loads and stores; bytes are never misaligned.
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        case (funct3[1:0])
            2'b01:   mis = addr_lo[0];
            2'b10:   mis = (addr_lo != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_data_align.sv
// Combinational lane steering: store data replication and byte strobes on the way out,
// byte/half extraction and sign/zero extension of the read word on the way back.
module lsu_data_align
    import rv_mem_pkg::*;
(
    input  logic [2:0]  st_funct3_i,
    input  logic [1:0]  st_addr_lo_i,
    input  logic [31:0] st_data_i,
    output logic [31:0] st_wdata_o,
    output logic [3:0]  st_wstrb_o,
    input  logic [2:0]  ld_funct3_i,
    input  logic [1:0]  ld_addr_lo_i,
    input  logic [31:0] ld_rdata_i,
    output logic [31:0] ld_data_o
);

    logic [31:0] ld_shift;

    always_comb begin
        st_wdata_o = st_data_i;
        st_wstrb_o = 4'b1111;
        case (st_funct3_i[1:0])
            2'b00: begin
                st_wdata_o = {4{st_data_i[7:0]}};
                st_wstrb_o = 4'b0001 << st_addr_lo_i;
            end
            2'b01: begin
                st_wdata_o = {2{st_data_i[15:0]}};
                st_wstrb_o = 4'b0011 << {st_addr_lo_i[1], 1'b0};
            end
            default: ;
        endcase
    end

    // Shift the addressed byte/half down to bit 0, then extend.
    always_comb begin
        ld_shift  = ld_rdata_i >> {ld_addr_lo_i, 3'b000};
        ld_data_o = ld_rdata_i;
        case (ld_funct3_i)
            F3_LB:   ld_data_o = {{24{ld_shift[7]}}, ld_shift[7:0]};
            F3_LBU:  ld_data_o = {24'h000000, ld_shift[7:0]};
            F3_LH:   ld_data_o = {{16{ld_shift[15]}}, ld_shift[15:0]};
            F3_LHU:  ld_data_o = {16'h0000, ld_shift[15:0]};
            default: ld_data_o = ld_rdata_i;
        endcase
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory sequencer: one valid/ready request per load/store, response wait with
// timeout, pipeline stall, and a single DONE cycle carrying load data or an exception.
module dmem_access_ctrl
    import rv_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ex_valid,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_wdata,
    output logic        dbus_req_valid,
    input  logic        dbus_req_ready,
    output logic        dbus_req_we,
    output logic [31:0] dbus_req_addr,
    output logic [31:0] dbus_req_wdata,
    output logic [3:0]  dbus_req_wstrb,
    input  logic        dbus_rsp_valid,
    input  logic [31:0] dbus_rsp_rdata,
    input  logic        dbus_rsp_err,
    output logic        mem_stall,
    output logic [31:0] load_data,
    output logic        exc_valid,
    output logic [3:0]  exc_cause,
    output logic [31:0] exc_tval,
    output mem_state_e  dbg_state
);

    // Request channel: dbus_req_valid rises with all fields registered, then valid and fields
    // stay constant until the cycle dbus_req_ready is high (handshake) or the timeout fires.
    // Responses are always accepted and only acted on in RESP.

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    mem_state_e  state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic        req_valid_q, req_valid_d;
    logic        req_we_q, req_we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] req_wdata_q, req_wdata_d;
    logic [3:0]  req_wstrb_q, req_wstrb_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] load_data_q, load_data_d;
    logic        exc_valid_q, exc_valid_d;
    logic [3:0]  exc_cause_q, exc_cause_d;
    logic [31:0] exc_tval_q, exc_tval_d;

    logic        op;
    logic        timeout_hit;
    logic [31:0] st_wdata;
    logic [3:0]  st_wstrb;
    logic [31:0] ld_data;

    lsu_data_align u_align (
        .st_funct3_i  (ex_funct3),
        .st_addr_lo_i (ex_addr[1:0]),
        .st_data_i    (ex_wdata),
        .st_wdata_o   (st_wdata),
        .st_wstrb_o   (st_wstrb),
        .ld_funct3_i  (funct3_q),
        .ld_addr_lo_i (addr_q[1:0]),
        .ld_rdata_i   (dbus_rsp_rdata),
        .ld_data_o    (ld_data)
    );

    assign op          = ex_valid & (ex_mem_read | ex_mem_write);
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (32'(cnt_q) >= TIMEOUT_CYCLES - 1);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_valid_d = req_valid_q;
        req_we_d    = req_we_q;
        addr_d      = addr_q;
        req_wdata_d = req_wdata_q;
        req_wstrb_d = req_wstrb_q;
        funct3_d    = funct3_q;
        load_data_d = load_data_q;
        exc_valid_d = exc_valid_q;
        exc_cause_d = exc_cause_q;
        exc_tval_d  = exc_tval_q;

        unique case (state_q)
            ST_IDLE: begin
                if (op) begin
                    if (is_misaligned(ex_funct3, ex_addr[1:0])) begin
                        state_d     = ST_DONE;
                        exc_valid_d = 1'b1;
                        exc_cause_d = ex_mem_write ? CAUSE_STORE_MISALIGNED : CAUSE_LOAD_MISALIGNED;
                        exc_tval_d  = ex_addr;
                    end else begin
                        state_d     = ST_REQ;
                        cnt_d       = '0;
                        req_valid_d = 1'b1;
                        req_we_d    = ex_mem_write;
                        addr_d      = ex_addr;
                        req_wdata_d = ex_mem_write ? st_wdata : 32'h0;
                        req_wstrb_d = ex_mem_write ? st_wstrb : 4'h0;
                        funct3_d    = ex_funct3;
                    end
                end
            end
            ST_REQ: begin
                cnt_d = cnt_q + CNT_W'(1);
                // A handshake in the limit cycle still wins; RESP then times out next cycle.
                if (dbus_req_ready) begin
                    req_valid_d = 1'b0;
                    state_d     = ST_RESP;
                end else if (timeout_hit) begin
                    req_valid_d = 1'b0;
                    state_d     = ST_DONE;
                    exc_valid_d = 1'b1;
                    exc_cause_d = req_we_q ? CAUSE_STORE_FAULT : CAUSE_LOAD_FAULT;
                    exc_tval_d  = addr_q;
                end
            end
            ST_RESP: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (dbus_rsp_valid) begin
                    state_d = ST_DONE;
                    if (dbus_rsp_err) begin
                        exc_valid_d = 1'b1;
                        exc_cause_d = req_we_q ? CAUSE_STORE_FAULT : CAUSE_LOAD_FAULT;
                        exc_tval_d  = addr_q;
                    end else begin
                        load_data_d = req_we_q ? 32'h0 : ld_data;
                    end
                end else if (timeout_hit) begin
                    state_d     = ST_DONE;
                    exc_valid_d = 1'b1;
                    exc_cause_d = req_we_q ? CAUSE_STORE_FAULT : CAUSE_LOAD_FAULT;
                    exc_tval_d  = addr_q;
                end
            end
            ST_DONE: begin
                state_d     = ST_IDLE;
                load_data_d = 32'h0;
                exc_valid_d = 1'b0;
                exc_cause_d = 4'h0;
                exc_tval_d  = 32'h0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            req_valid_q <= 1'b0;
            req_we_q    <= 1'b0;
            addr_q      <= 32'h0;
            req_wdata_q <= 32'h0;
            req_wstrb_q <= 4'h0;
            funct3_q    <= 3'h0;
            load_data_q <= 32'h0;
            exc_valid_q <= 1'b0;
            exc_cause_q <= 4'h0;
            exc_tval_q  <= 32'h0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_valid_q <= req_valid_d;
            req_we_q    <= req_we_d;
            addr_q      <= addr_d;
            req_wdata_q <= req_wdata_d;
            req_wstrb_q <= req_wstrb_d;
            funct3_q    <= funct3_d;
            load_data_q <= load_data_d;
            exc_valid_q <= exc_valid_d;
            exc_cause_q <= exc_cause_d;
            exc_tval_q  <= exc_tval_d;
        end
    end

    assign mem_stall      = op & (state_q != ST_DONE);
    assign dbus_req_valid = req_valid_q;
    assign dbus_req_we    = req_we_q;
    assign dbus_req_addr  = {addr_q[31:2], 2'b00};
    assign dbus_req_wdata = req_wdata_q;
    assign dbus_req_wstrb = req_wstrb_q;
    assign load_data      = load_data_q;
    assign exc_valid      = exc_valid_q;
    assign exc_cause      = exc_cause_q;
    assign exc_tval       = exc_tval_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: directed vector table, randomized accesses against a
// byte-arithmetic reference model, and hand sequences for stray responses and reset.
module tb_dmem_access_ctrl;
    import rv_mem_pkg::*;

    localparam int TO    = 8;
    localparam int NEVER = 99;

    logic        clk;
    logic        reset_n;
    logic        ex_valid;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_addr;
    logic [31:0] ex_wdata;
    logic        dbus_req_valid;
    logic        dbus_req_ready;
    logic        dbus_req_we;
    logic [31:0] dbus_req_addr;
    logic [31:0] dbus_req_wdata;
    logic [3:0]  dbus_req_wstrb;
    logic        dbus_rsp_valid;
    logic [31:0] dbus_rsp_rdata;
    logic        dbus_rsp_err;
    logic        mem_stall;
    logic [31:0] load_data;
    logic        exc_valid;
    logic [3:0]  exc_cause;
    logic [31:0] exc_tval;
    mem_state_e  dbg_state;

    dmem_access_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .ex_valid       (ex_valid),
        .ex_mem_read    (ex_mem_read),
        .ex_mem_write   (ex_mem_write),
        .ex_funct3      (ex_funct3),
        .ex_addr        (ex_addr),
        .ex_wdata       (ex_wdata),
        .dbus_req_valid (dbus_req_valid),
        .dbus_req_ready (dbus_req_ready),
        .dbus_req_we    (dbus_req_we),
        .dbus_req_addr  (dbus_req_addr),
        .dbus_req_wdata (dbus_req_wdata),
        .dbus_req_wstrb (dbus_req_wstrb),
        .dbus_rsp_valid (dbus_rsp_valid),
        .dbus_rsp_rdata (dbus_rsp_rdata),
        .dbus_rsp_err   (dbus_rsp_err),
        .mem_stall      (mem_stall),
        .load_data      (load_data),
        .exc_valid      (exc_valid),
        .exc_cause      (exc_cause),
        .exc_tval       (exc_tval),
        .dbg_state      (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rdata;
        logic        err;
        int          rdy_dly;
        int          rsp_dly;
        int          exp_stall;
        logic        exp_req;
        logic        exp_exc;
        logic [3:0]  exp_cause;
        logic [31:0] exp_ld;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_wstrb;
    } vec_t;

    vec_t dir_tab[14];
    vec_t rv;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%08h required=%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wd, input logic [31:0] rdata, input logic err,
                                input int rdy, input int rsp, input int stall, input logic req,
                                input logic exc, input logic [3:0] cause, input logic [31:0] ld,
                                input logic [31:0] eaddr, input logic [31:0] ewd,
                                input logic [3:0] estrb);
        vec_t v;
        v.rd = !wr; v.wr = wr; v.f3 = f3; v.addr = addr; v.wd = wd; v.rdata = rdata;
        v.err = err; v.rdy_dly = rdy; v.rsp_dly = rsp; v.exp_stall = stall; v.exp_req = req;
        v.exp_exc = exc; v.exp_cause = cause; v.exp_ld = ld; v.exp_addr = eaddr;
        v.exp_wdata = ewd; v.exp_wstrb = estrb;
        return v;
    endfunction

    // Reference model: size/offset arithmetic and a cycle budget, no state machine.
    function automatic vec_t model(input vec_t v);
        int size;
        int n;
        logic [31:0] w;
        logic [31:0] mask;
        logic [31:0] rep;
        size = 1 << v.f3[1:0];
        v.exp_exc = 1'b0; v.exp_cause = 4'h0; v.exp_ld = 32'h0; v.exp_req = 1'b0;
        v.exp_addr = v.addr & 32'hFFFF_FFFC;
        mask = (size == 1) ? 32'h0000_00FF : (size == 2) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
        rep  = (size == 1) ? 32'h0101_0101 : (size == 2) ? 32'h0001_0001 : 32'h0000_0001;
        v.exp_wdata = v.wr ? (v.wd & mask) * rep : 32'h0;
        v.exp_wstrb = v.wr ? 4'(((1 << size) - 1) << v.addr[1:0]) : 4'h0;
        if ((v.addr % size) != 0) begin
            v.exp_exc = 1'b1; v.exp_cause = v.wr ? 4'd6 : 4'd4; v.exp_stall = 1;
        end else begin
            v.exp_req = 1'b1;
            n = v.rdy_dly + v.rsp_dly + 2;
            if (n > TO) begin
                v.exp_exc = 1'b1; v.exp_cause = v.wr ? 4'd7 : 4'd5; v.exp_stall = TO + 1;
            end else begin
                v.exp_stall = n + 1;
                if (v.err) begin
                    v.exp_exc = 1'b1; v.exp_cause = v.wr ? 4'd7 : 4'd5;
                end else if (!v.wr) begin
                    w = v.rdata >> (8 * v.addr[1:0]);
                    v.exp_ld = w & mask;
                    if (!v.f3[2] && size == 1 && w[7])  v.exp_ld = v.exp_ld | 32'hFFFF_FF00;
                    if (!v.f3[2] && size == 2 && w[15]) v.exp_ld = v.exp_ld | 32'hFFFF_0000;
                end
            end
        end
        return v;
    endfunction

    // Called at posedge+1 with the DUT in IDLE; plays the bus and checks the DONE cycle.
    task automatic run_access(input vec_t v, input string tag);
        int  stall;
        int  req_wait;
        int  rsp_wait;
        bit  in_resp;
        bit  hs;
        bit  req_seen;
        bit  req_bad;
        bit  exc_early;
        bit  done;
        stall = 0; req_wait = 0; rsp_wait = 0; in_resp = 0; req_seen = 0;
        req_bad = 0; exc_early = 0; done = 0;
        ex_valid = 1'b1; ex_mem_read = v.rd; ex_mem_write = v.wr;
        ex_funct3 = v.f3; ex_addr = v.addr; ex_wdata = v.wd;
        for (int c = 0; c < 40 && !done; c++) begin
            #1;
            dbus_req_ready = 1'b0; dbus_rsp_valid = 1'b0; dbus_rsp_err = 1'b0;
            dbus_rsp_rdata = 32'h0;
            hs = 0;
            if (dbus_req_valid) begin
                req_seen = 1;
                if (dbus_req_addr !== v.exp_addr || dbus_req_we !== v.wr ||
                    dbus_req_wdata !== v.exp_wdata || dbus_req_wstrb !== v.exp_wstrb)
                    req_bad = 1;
                if (req_wait >= v.rdy_dly) begin
                    dbus_req_ready = 1'b1;
                    hs = 1;
                end else begin
                    req_wait++;
                end
            end else if (in_resp) begin
                if (rsp_wait >= v.rsp_dly) begin
                    dbus_rsp_valid = 1'b1; dbus_rsp_rdata = v.rdata; dbus_rsp_err = v.err;
                end else begin
                    rsp_wait++;
                end
            end
            #1;
            if (!mem_stall) begin
                done = 1;
                check({tag, " stall_cycles"}, stall, v.exp_stall);
                check({tag, " exc_valid"}, exc_valid, v.exp_exc);
                if (v.exp_exc) begin
                    check({tag, " exc_cause"}, exc_cause, v.exp_cause);
                    check({tag, " exc_tval"}, exc_tval, v.addr);
                end
                check({tag, " load_data"}, load_data, v.exp_ld);
                check({tag, " req_issued"}, req_seen, v.exp_req);
                if (v.exp_req) check({tag, " req_fields_stable"}, req_bad, 0);
                check({tag, " exc_outside_done"}, exc_early, 0);
            end else begin
                stall++;
                if (exc_valid) exc_early = 1;
                @(posedge clk);
                #1;
                if (hs) in_resp = 1;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s done_bound actual=no_done required=done_within_40", tag);
        end
        @(posedge clk);
        #1;
        dbus_req_ready = 1'b0; dbus_rsp_valid = 1'b0; dbus_rsp_err = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " req_valid"}, dbus_req_valid, 0);
        check({tag, " req_we"}, dbus_req_we, 0);
        check({tag, " req_addr"}, dbus_req_addr, 0);
        check({tag, " req_wdata"}, dbus_req_wdata, 0);
        check({tag, " req_wstrb"}, dbus_req_wstrb, 0);
        check({tag, " load_data"}, load_data, 0);
        check({tag, " exc_valid"}, exc_valid, 0);
        check({tag, " exc_cause"}, exc_cause, 0);
        check({tag, " exc_tval"}, exc_tval, 0);
        check({tag, " state"}, dbg_state, ST_IDLE);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int size;
        logic [1:0] lo;
        // wr f3 addr wd rdata err rdy rsp | stall req exc cause ld req_addr wdata wstrb
        dir_tab[0]  = mk(0, F3_LW,  32'h100, 32'h0, 32'hDEADBEEF, 0, 0, 0,
                         3, 1, 0, 4'd0, 32'hDEADBEEF, 32'h100, 32'h0, 4'h0);
        dir_tab[1]  = mk(0, F3_LB,  32'h103, 32'h0, 32'h80FFFF7F, 0, 0, 0,
                         3, 1, 0, 4'd0, 32'hFFFFFF80, 32'h100, 32'h0, 4'h0);
        dir_tab[2]  = mk(0, F3_LBU, 32'h103, 32'h0, 32'h80FFFF7F, 0, 0, 0,
                         3, 1, 0, 4'd0, 32'h00000080, 32'h100, 32'h0, 4'h0);
        dir_tab[3]  = mk(1, F3_SH,  32'h202, 32'h1234ABCD, 32'h5555, 0, 0, 0,
                         3, 1, 0, 4'd0, 32'h0, 32'h200, 32'hABCDABCD, 4'b1100);
        dir_tab[4]  = mk(0, F3_LW,  32'h101, 32'h0, 32'h0, 0, 0, 0,
                         1, 0, 1, 4'd4, 32'h0, 32'h100, 32'h0, 4'h0);
        dir_tab[5]  = mk(1, F3_SW,  32'h300, 32'hCAFEF00D, 32'h0, 1, 5, 0,
                         8, 1, 1, 4'd7, 32'h0, 32'h300, 32'hCAFEF00D, 4'hF);
        dir_tab[6]  = mk(0, F3_LW,  32'h400, 32'h0, 32'h0, 0, 0, NEVER,
                         9, 1, 1, 4'd5, 32'h0, 32'h400, 32'h0, 4'h0);
        dir_tab[7]  = mk(1, F3_SH,  32'h201, 32'h1111, 32'h0, 0, 0, 0,
                         1, 0, 1, 4'd6, 32'h0, 32'h200, 32'h0, 4'h0);
        dir_tab[8]  = mk(0, F3_LH,  32'h102, 32'h0, 32'h80010000, 0, 0, 0,
                         3, 1, 0, 4'd0, 32'hFFFF8001, 32'h100, 32'h0, 4'h0);
        dir_tab[9]  = mk(0, F3_LHU, 32'h102, 32'h0, 32'h80010000, 0, 0, 0,
                         3, 1, 0, 4'd0, 32'h00008001, 32'h100, 32'h0, 4'h0);
        dir_tab[10] = mk(1, F3_SB,  32'h101, 32'h000000A5, 32'h0, 0, NEVER, 0,
                         9, 1, 1, 4'd7, 32'h0, 32'h100, 32'hA5A5A5A5, 4'b0010);
        dir_tab[11] = mk(0, F3_LB,  32'h100, 32'h0, 32'h12345678, 1, 1, 2,
                         6, 1, 1, 4'd5, 32'h0, 32'h100, 32'h0, 4'h0);
        dir_tab[12] = mk(1, F3_SB,  32'h102, 32'h00000077, 32'h0, 0, 0, 1,
                         4, 1, 0, 4'd0, 32'h0, 32'h100, 32'h77777777, 4'b0100);
        dir_tab[13] = mk(0, F3_LH,  32'h101, 32'h0, 32'h0, 0, 0, 0,
                         1, 0, 1, 4'd4, 32'h0, 32'h100, 32'h0, 4'h0);

        reset_n = 1'b0;
        ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
        ex_funct3 = 3'h0; ex_addr = 32'h0; ex_wdata = 32'h0;
        dbus_req_ready = 1'b0; dbus_rsp_valid = 1'b0; dbus_rsp_rdata = 32'h0; dbus_rsp_err = 1'b0;
        #3;
        check_reset_outputs("reset");
        check("reset mem_stall", mem_stall, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 14; i++) run_access(dir_tab[i], $sformatf("dir%0d", i));

        // Late response after a timeout, while idle, must be ignored.
        run_access(dir_tab[6], "timeout_again");
        ex_valid = 1'b0;
        #1;
        dbus_rsp_valid = 1'b1; dbus_rsp_rdata = 32'hFFFF_FFFF; dbus_rsp_err = 1'b1;
        #1;
        check("stray mem_stall", mem_stall, 0);
        @(posedge clk);
        #1;
        dbus_rsp_valid = 1'b0; dbus_rsp_err = 1'b0;
        check("stray state", dbg_state, ST_IDLE);
        check("stray exc_valid", exc_valid, 0);
        check("stray load_data", load_data, 0);

        // Valid instruction that is neither load nor store: no stall, no request.
        ex_valid = 1'b1; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
        #1;
        check("nonmem mem_stall", mem_stall, 0);
        @(posedge clk);
        #1;
        check("nonmem req_valid", dbus_req_valid, 0);
        check("nonmem state", dbg_state, ST_IDLE);

        for (int i = 0; i < 40; i++) begin
            rv.wr = ($urandom_range(0, 2) == 0);
            rv.rd = !rv.wr;
            if (rv.wr) begin
                case ($urandom_range(0, 2))
                    0:       rv.f3 = F3_SB;
                    1:       rv.f3 = F3_SH;
                    default: rv.f3 = F3_SW;
                endcase
            end else begin
                case ($urandom_range(0, 4))
                    0:       rv.f3 = F3_LB;
                    1:       rv.f3 = F3_LH;
                    2:       rv.f3 = F3_LW;
                    3:       rv.f3 = F3_LBU;
                    default: rv.f3 = F3_LHU;
                endcase
            end
            size = 1 << rv.f3[1:0];
            lo = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0) lo = lo & ~2'(size - 1);
            rv.addr    = ($urandom & 32'hFFFF_FFFC) | {30'h0, lo};
            rv.wd      = $urandom;
            rv.rdata   = $urandom;
            rv.err     = ($urandom_range(0, 7) == 0);
            rv.rdy_dly = $urandom_range(0, 3);
            rv.rsp_dly = $urandom_range(0, 3);
            rv = model(rv);
            run_access(rv, $sformatf("rnd%0d", i));
        end

        // Reset while waiting for a response.
        ex_valid = 1'b1; ex_mem_read = 1'b1; ex_mem_write = 1'b0;
        ex_funct3 = F3_LW; ex_addr = 32'h500;
        @(posedge clk);
        #1;
        dbus_req_ready = 1'b1;
        @(posedge clk);
        #1;
        dbus_req_ready = 1'b0;
        check("midreset pre_state", dbg_state, ST_RESP);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        check("midreset mem_stall", mem_stall, 1);
        ex_valid = 1'b0;
        #1;
        check("midreset mem_stall_idle", mem_stall, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
